pipeline_hazard_ctrl: RTL and testbench

//  Parametrised in-flight write tracker for the cpu_core pipeline.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 76 +++++++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default sizes for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned HzRegAddrW = 5;
   localparam int unsigned HzDataW    = 32;
   localparam int unsigned HzDepth    = 3;

   // Where a forwarded operand comes from for one source register
   typedef enum logic [1:0] {
      FwdNone,
      FwdEx,
      FwdMem,
      FwdStored
   } fwd_src_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX/WB-side signal bundle for the hazard controller.
interface pipeline_hazard_ctrl_if
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = HzRegAddrW,
   parameter int unsigned DATA_W     = HzDataW
);

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_we;
   logic                  id_late;
   logic [DATA_W-1:0]     ex_result;
   logic [DATA_W-1:0]     mem_result;
   logic                  flush;
   logic                  stall;
   logic                  fwd1_hit;
   logic [DATA_W-1:0]     fwd1_data;
   logic                  fwd2_hit;
   logic [DATA_W-1:0]     fwd2_data;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0]     wb_data;

   // Pipeline side: issues instructions and reports results
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_late,
      output ex_result, mem_result, flush,
      input  stall, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, wb_valid, wb_rd, wb_data
   );

   // Hazard controller side
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_late,
      input  ex_result, mem_result, flush,
      output stall, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, wb_valid, wb_rd, wb_data
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding priority search for one source register (hazard_fwd_select).
// Youngest matching in-flight entry wins; a late result still in EX is a hazard.
module pipeline_hazard_ctrl_fwd_select
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = HzRegAddrW,
   parameter int unsigned DATA_W     = HzDataW,
   parameter int unsigned DEPTH      = HzDepth,
   parameter bit          ZERO_REG   = 1'b1
) (
   input  logic [DEPTH-1:0]                 valid,
   input  logic [DEPTH-1:0]                 we,
   input  logic [DEPTH-1:0]                 late,
   input  logic [DEPTH-1:0]                 ready,
   input  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd,
   input  logic [DEPTH-1:0][DATA_W-1:0]     data,
   input  logic [REG_ADDR_W-1:0]            src,
   input  logic                             used,
   input  logic [DATA_W-1:0]                ex_result,
   input  logic [DATA_W-1:0]                mem_result,
   output logic                             hit,
   output logic [DATA_W-1:0]                fwd_data,
   output logic                             late_hazard
);

   fwd_src_e          sel;
   logic [DATA_W-1:0] stored;
   logic              src_zero;

   assign src_zero = ZERO_REG && (src == '0);

   // Scan oldest to youngest so the youngest match overrides older ones
   always_comb begin
      sel         = FwdNone;
      late_hazard = 1'b0;
      stored      = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid[i] && we[i] && used && (rd[i] == src) && !src_zero) begin
            sel         = FwdNone;
            late_hazard = 1'b0;
            stored      = '0;
            if (i == 0) begin
               if (late[0]) late_hazard = 1'b1;
               else         sel = FwdEx;
            end else if ((i == 1) && late[1]) begin
               sel = FwdMem;
            end else if (ready[i]) begin
               sel    = FwdStored;
               stored = data[i];
            end
         end
      end
   end

   // Drive the operand from the selected source
   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      unique case (sel)
         FwdEx: begin
            hit      = 1'b1;
            fwd_data = ex_result;
         end
         FwdMem: begin
            hit      = 1'b1;
            fwd_data = mem_result;
         end
         FwdStored: begin
            hit      = 1'b1;
            fwd_data = stored;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// In-flight write tracker: forwarding to ID, load-use stall, register-file retire.
// e[0] is EX, e[1] is MEM, e[DEPTH-1] is WB.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = HzRegAddrW,
   parameter int unsigned DATA_W     = HzDataW,
   parameter int unsigned DEPTH      = HzDepth,
   parameter bit          ZERO_REG   = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave bus
);

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic                  late;
      logic [REG_ADDR_W-1:0] rd;
      logic                  ready;
      logic [DATA_W-1:0]     data;
   } entry_t;

   entry_t e_q [DEPTH];
   entry_t e_d [DEPTH];

   logic                             stall;
   logic                             issue;
   logic [DEPTH-1:0]                 valid_v;
   logic [DEPTH-1:0]                 we_v;
   logic [DEPTH-1:0]                 late_v;
   logic [DEPTH-1:0]                 ready_v;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_v;
   logic [DEPTH-1:0][DATA_W-1:0]     data_v;
   logic                             hit1;
   logic                             hit2;
   logic                             haz1;
   logic                             haz2;
   logic [DATA_W-1:0]                data1;
   logic [DATA_W-1:0]                data2;

   function automatic entry_t new_entry(logic we, logic late, logic [REG_ADDR_W-1:0] rd);
      entry_t e;
      e       = '0;
      e.valid = 1'b1;
      e.we    = we;
      e.late  = late;
      e.rd    = rd;
      return e;
   endfunction

   function automatic entry_t capture(entry_t e, logic [DATA_W-1:0] result);
      entry_t c;
      c       = e;
      c.ready = 1'b1;
      c.data  = result;
      return c;
   endfunction

   // Flush outranks the load-use stall
   assign stall = bus.id_valid && !bus.flush && (haz1 || haz2);
   assign issue = bus.id_valid && !stall && !bus.flush;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (i == 0) begin : g_ex
         assign e_d[0] = issue ? new_entry(bus.id_we, bus.id_late, bus.id_rd) : '0;
      end else if (i == 1) begin : g_mem
         // Squashed EX entry never reaches MEM; ALU results are captured leaving EX
         assign e_d[1] = (!e_q[0].valid || bus.flush) ? '0 :
                         e_q[0].late ? e_q[0] : capture(e_q[0], bus.ex_result);
      end else if (i == 2) begin : g_mem_out
         // Loads capture their data leaving MEM
         assign e_d[2] = !e_q[1].valid ? '0 :
                         e_q[1].late ? capture(e_q[1], bus.mem_result) : e_q[1];
      end else begin : g_tail
         assign e_d[i] = e_q[i-1];
      end

      assign valid_v[i] = e_q[i].valid;
      assign we_v[i]    = e_q[i].we;
      assign late_v[i]  = e_q[i].late;
      assign ready_v[i] = e_q[i].ready;
      assign rd_v[i]    = e_q[i].rd;
      assign data_v[i]  = e_q[i].data;
   end

   // Every stage advances each cycle; a stall only turns the new e[0] into a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) e_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) e_q[i] <= e_d[i];
      end
   end

   pipeline_hazard_ctrl_fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .ZERO_REG   (ZERO_REG)
   ) u_fwd1 (
      .valid       (valid_v),
      .we          (we_v),
      .late        (late_v),
      .ready       (ready_v),
      .rd          (rd_v),
      .data        (data_v),
      .src         (bus.id_rs1),
      .used        (bus.id_rs1_used),
      .ex_result   (bus.ex_result),
      .mem_result  (bus.mem_result),
      .hit         (hit1),
      .fwd_data    (data1),
      .late_hazard (haz1)
   );

   pipeline_hazard_ctrl_fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .ZERO_REG   (ZERO_REG)
   ) u_fwd2 (
      .valid       (valid_v),
      .we          (we_v),
      .late        (late_v),
      .ready       (ready_v),
      .rd          (rd_v),
      .data        (data_v),
      .src         (bus.id_rs2),
      .used        (bus.id_rs2_used),
      .ex_result   (bus.ex_result),
      .mem_result  (bus.mem_result),
      .hit         (hit2),
      .fwd_data    (data2),
      .late_hazard (haz2)
   );

   assign bus.stall     = stall;
   assign bus.fwd1_hit  = hit1;
   assign bus.fwd1_data = data1;
   assign bus.fwd2_hit  = hit2;
   assign bus.fwd2_data = data2;

   // Retire straight from the registered WB entry
   assign bus.wb_valid = e_q[DEPTH-1].valid && e_q[DEPTH-1].we &&
                         !(ZERO_REG && (e_q[DEPTH-1].rd == '0));
   assign bus.wb_rd    = e_q[DEPTH-1].rd;
   assign bus.wb_data  = e_q[DEPTH-1].data;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// checked against an issue-time based model of in-flight instructions.
module tb_pipeline_hazard_ctrl;

   localparam int D = 3;

   logic clk;
   logic rst;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .DATA_W(32)) bus ();

   pipeline_hazard_ctrl #(
      .REG_ADDR_W (5),
      .DATA_W     (32),
      .DEPTH      (D),
      .ZERO_REG   (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      bit          we;
      bit          late;
      int          issue;
      logic [31:0] val;
   } inst_t;

   inst_t q[$];
   int    cyc;
   int    n_checks;
   int    n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Cycles spent past ID: 0 = EX, 1 = MEM, D-1 = WB
   function automatic int stage_of(int k);
      return cyc - q[k].issue - 1;
   endfunction

   function automatic void lookup(input logic [4:0] s, input logic used, output bit hit,
                                  output logic [31:0] d, output bit haz);
      hit = 0;
      d   = '0;
      haz = 0;
      if (!used || s == 5'd0) return;
      for (int k = q.size() - 1; k >= 0; k--) begin
         int st;
         st = stage_of(k);
         if (st >= 0 && st < D && q[k].we && q[k].rd == s) begin
            if (st == 0 && q[k].late) haz = 1;
            else if (st == 0) begin hit = 1; d = bus.ex_result; end
            else if (st == 1 && q[k].late) begin hit = 1; d = bus.mem_result; end
            else begin hit = 1; d = q[k].val; end
            return;
         end
      end
   endfunction

   function automatic bit exp_stall();
      bit h; bit z1; bit z2; logic [31:0] d;
      lookup(bus.id_rs1, bus.id_rs1_used, h, d, z1);
      lookup(bus.id_rs2, bus.id_rs2_used, h, d, z2);
      return bus.id_valid && !bus.flush && (z1 || z2);
   endfunction

   task automatic model_check();
      bit h1, h2, z1, z2, wv;
      logic [31:0] d1, d2, wd;
      logic [4:0]  wr;
      lookup(bus.id_rs1, bus.id_rs1_used, h1, d1, z1);
      lookup(bus.id_rs2, bus.id_rs2_used, h2, d2, z2);
      chk("stall", bus.stall, exp_stall());
      chk("fwd1_hit", bus.fwd1_hit, h1);
      chk("fwd1_data", bus.fwd1_data, d1);
      chk("fwd2_hit", bus.fwd2_hit, h2);
      chk("fwd2_data", bus.fwd2_data, d2);
      wv = 0; wr = '0; wd = '0;
      foreach (q[k]) begin
         if (stage_of(k) == D - 1) begin
            wv = q[k].we && q[k].rd != 5'd0;
            wr = q[k].rd;
            wd = q[k].val;
         end
      end
      chk("wb_valid", bus.wb_valid, wv);
      if (wv) begin
         chk("wb_rd", bus.wb_rd, wr);
         chk("wb_data", bus.wb_data, wd);
      end
   endtask

   task automatic model_update();
      bit st_now;
      inst_t ni;
      st_now = exp_stall();
      foreach (q[k]) begin
         if (stage_of(k) == 0 && !q[k].late) q[k].val = bus.ex_result;
         if (stage_of(k) == 1 && q[k].late)  q[k].val = bus.mem_result;
      end
      if (bus.flush) begin
         for (int k = q.size() - 1; k >= 0; k--) if (stage_of(k) == 0) q.delete(k);
      end
      if (bus.id_valid && !bus.flush && !st_now) begin
         ni.rd = bus.id_rd; ni.we = bus.id_we; ni.late = bus.id_late;
         ni.issue = cyc; ni.val = '0;
         q.push_back(ni);
      end
      cyc++;
      while (q.size() > 0 && stage_of(0) >= D) void'(q.pop_front());
   endtask

   task automatic tick();
      #1;
      model_check();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                         input bit u2, input logic [4:0] rd, input bit we, input bit late);
      bus.id_valid = v;   bus.id_rs1 = r1; bus.id_rs1_used = u1;
      bus.id_rs2 = r2;    bus.id_rs2_used = u2;
      bus.id_rd = rd;     bus.id_we = we;  bus.id_late = late;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      bus.flush      = 1'b0;
      bus.ex_result  = $urandom;
      bus.mem_result = $urandom;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0;
      rst = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst stall", bus.stall, 0);
      chk("rst fwd1_hit", bus.fwd1_hit, 0);
      chk("rst fwd1_data", bus.fwd1_data, 0);
      chk("rst fwd2_hit", bus.fwd2_hit, 0);
      chk("rst fwd2_data", bus.fwd2_data, 0);
      chk("rst wb_valid", bus.wb_valid, 0);
      chk("rst wb_rd", bus.wb_rd, 0);
      chk("rst wb_data", bus.wb_data, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: ALU dependency forwarded from EX
      idle(); set_id(1, 0, 0, 0, 0, 5, 1, 0); tick();
      idle(); bus.ex_result = 32'h1234; set_id(1, 5, 1, 0, 0, 6, 1, 0); #1;
      chk("t1 fwd1_hit", bus.fwd1_hit, 1);
      chk("t1 fwd1_data", bus.fwd1_data, 32'h1234);
      chk("t1 stall", bus.stall, 0);
      tick();
      repeat (3) begin idle(); tick(); end

      // 2: load-use costs one bubble, then forward from MEM
      idle(); set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
      idle(); set_id(1, 3, 1, 0, 0, 4, 1, 0); #1;
      chk("t2 stall", bus.stall, 1);
      tick();
      bus.mem_result = 32'hDEAD; #1;
      chk("t2 stall after", bus.stall, 0);
      chk("t2 fwd1_hit", bus.fwd1_hit, 1);
      chk("t2 fwd1_data", bus.fwd1_data, 32'hDEAD);
      tick();
      repeat (3) begin idle(); tick(); end

      // 3: two producers of x7, youngest wins
      idle(); set_id(1, 0, 0, 0, 0, 7, 1, 0); tick();
      idle(); bus.ex_result = 32'h11; set_id(1, 0, 0, 0, 0, 7, 1, 0); tick();
      idle(); bus.ex_result = 32'h22; tick();
      idle(); set_id(1, 0, 0, 7, 1, 0, 0, 0); #1;
      chk("t3 fwd2_hit", bus.fwd2_hit, 1);
      chk("t3 fwd2_data", bus.fwd2_data, 32'h22);
      chk("t3 wb_data", bus.wb_data, 32'h11);
      tick();
      repeat (3) begin idle(); tick(); end

      // 4: x0 never forwards or retires
      idle(); set_id(1, 0, 0, 0, 0, 0, 1, 0); tick();
      idle(); bus.ex_result = 32'h55; set_id(1, 0, 1, 0, 0, 0, 0, 0); #1;
      chk("t4 fwd1_hit", bus.fwd1_hit, 0);
      tick();
      repeat (4) begin idle(); #1; chk("t4 wb_valid", bus.wb_valid, 0); tick(); end

      // 5: flush during a load-use stall
      idle(); set_id(1, 0, 0, 0, 0, 9, 1, 1); tick();
      idle(); set_id(1, 9, 1, 0, 0, 8, 1, 0); bus.flush = 1'b1; #1;
      chk("t5 stall", bus.stall, 0);
      tick();
      repeat (4) begin idle(); #1; chk("t5 wb_valid", bus.wb_valid, 0); tick(); end

      // 6: asynchronous reset with three entries in flight
      idle(); set_id(1, 0, 0, 0, 0, 10, 1, 0); tick();
      idle(); set_id(1, 0, 0, 0, 0, 11, 1, 0); tick();
      idle(); set_id(1, 0, 0, 0, 0, 12, 1, 0); tick();
      idle(); #1;
      chk("t6 wb_valid before", bus.wb_valid, 1);
      #1; rst = 1'b0; #1;
      chk("t6 wb_valid async", bus.wb_valid, 0);
      chk("t6 fwd1_hit", bus.fwd1_hit, 0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) begin idle(); #1; chk("t6 wb_valid after", bus.wb_valid, 0); tick(); end

      // Random traffic on a small register set to provoke overlaps
      repeat (400) begin
         idle();
         set_id($urandom_range(3) != 0, 5'($urandom_range(3)), $urandom_range(9) < 7,
                5'($urandom_range(3)), $urandom_range(9) < 7, 5'($urandom_range(3)),
                $urandom_range(9) < 7, $urandom_range(9) < 3);
         bus.flush = $urandom_range(9) == 0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
